// File: rtl/dc_filter_mc_if.sv
// Sample-bus bundle for dc_filter_mc: strobe, bypass and packed samples in;
// filtered samples, valid, clip, busy and overrun status out.
interface dc_filter_mc_if #(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 4
);
    logic                      enable_3M;
    logic                      i_bypass;
    logic [CHANNELS*WIDTH-1:0] c_data;
    logic [CHANNELS*WIDTH-1:0] o_data;
    logic                      o_valid;
    logic [CHANNELS-1:0]       o_clip;
    logic                      o_busy;
    logic                      o_overrun;

    modport master (
        output enable_3M, i_bypass, c_data,
        input  o_data, o_valid, o_clip, o_busy, o_overrun
    );

    modport slave (
        input  enable_3M, i_bypass, c_data,
        output o_data, o_valid, o_clip, o_busy, o_overrun
    );
endinterface

// File: rtl/dc_filter_mc.sv
// Multi-channel DC-blocking high-pass filter, y = x - x_prev + a*y_prev with
// a = 1 - 2^-SHIFT, one shared datapath stepping through the channels per strobe.
module dc_filter_mc #(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 4,
    parameter int SHIFT    = 18,
    parameter int SATURATE = 1
) (
    input logic           CLK_24M,
    input logic           reset,
    dc_filter_mc_if.slave bus
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int GW    = WIDTH + SHIFT + 1;
    localparam logic [IDX_W-1:0]         LAST   = IDX_W'(CHANNELS - 1);
    localparam logic signed [WIDTH-1:0]  MAXV_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]  MINV_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH+1:0]  MAXV   = (WIDTH+2)'(MAXV_W);
    localparam logic signed [WIDTH+1:0]  MINV   = (WIDTH+2)'(MINV_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [CHANNELS*WIDTH-1:0] r_xin;
    logic                      r_bypass;
    logic signed [WIDTH-1:0]   r_xprev [CHANNELS];
    logic signed [WIDTH-1:0]   r_yprev [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] r_shadow;
    logic [CHANNELS-1:0]       r_clip_sh;
    logic [CHANNELS*WIDTH-1:0] r_odata;
    logic [CHANNELS-1:0]       r_oclip;
    logic                      r_valid;
    logic                      r_busy;
    logic                      r_overrun;

    logic signed [WIDTH-1:0]   w_x;
    logic signed [WIDTH-1:0]   w_y;
    logic signed [WIDTH:0]     w_c;
    logic signed [WIDTH:0]     w_ha;
    logic signed [WIDTH+1:0]   w_d;
    logic                      w_clip;
    logic [CHANNELS*WIDTH-1:0] w_shadow_nxt;
    logic [CHANNELS-1:0]       w_clip_nxt;

    // y_prev * (1 - 2^-SHIFT), rounded half-up via the first discarded bit
    function automatic logic signed [WIDTH:0] scale_round(input logic signed [WIDTH-1:0] yp);
        logic signed [GW-1:0] ext;
        logic signed [GW-1:0] g;
        logic signed [GW-1:0] hr;
        ext = GW'(yp);
        g   = (ext <<< SHIFT) - ext;
        hr  = (g >>> SHIFT) + GW'({1'b0, g[SHIFT-1]});
        return (WIDTH+1)'(hr);
    endfunction

    function automatic logic signed [WIDTH-1:0] limit(input logic signed [WIDTH+1:0] d);
        if (SATURATE != 0 && d > MAXV) return MAXV_W;
        if (SATURATE != 0 && d < MINV) return MINV_W;
        return WIDTH'(d);
    endfunction

    function automatic logic out_of_range(input logic signed [WIDTH+1:0] d);
        return (d > MAXV) || (d < MINV);
    endfunction

    always_comb begin
        w_x          = r_xin[r_idx*WIDTH +: WIDTH];
        w_c          = (WIDTH+1)'(w_x) - (WIDTH+1)'(r_xprev[r_idx]);
        w_ha         = scale_round(r_yprev[r_idx]);
        w_d          = (WIDTH+2)'(w_c) + (WIDTH+2)'(w_ha);
        w_y          = r_bypass ? w_x : limit(w_d);
        w_clip       = r_bypass ? 1'b0 : out_of_range(w_d);
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[r_idx*WIDTH +: WIDTH] = w_y;
        w_clip_nxt   = r_clip_sh;
        w_clip_nxt[r_idx] = w_clip;
    end

    always_ff @(posedge CLK_24M) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_odata   <= '0;
            r_oclip   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_xprev[k] <= '0;
                r_yprev[k] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.enable_3M) begin
                        r_xin    <= bus.c_data;
                        r_bypass <= bus.i_bypass;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.enable_3M) r_overrun <= 1'b1;
                    r_xprev[r_idx] <= w_x;
                    r_yprev[r_idx] <= r_bypass ? '0 : w_y;
                    r_shadow       <= w_shadow_nxt;
                    r_clip_sh      <= w_clip_nxt;
                    // Publish on the last channel so o_valid lands in the DONE cycle
                    if (r_idx == LAST) begin
                        r_odata <= w_shadow_nxt;
                        r_oclip <= w_clip_nxt;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.enable_3M) r_overrun <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_data    = r_odata;
    assign bus.o_clip    = r_oclip;
    assign bus.o_valid   = r_valid;
    assign bus.o_busy    = r_busy;
    assign bus.o_overrun = r_overrun;
endmodule

// File: tb/tb_dc_filter_mc.sv
// Bench for dc_filter_mc: saturating and wrapping instances driven in lockstep,
// compared against a real-arithmetic reference model.
module tb_dc_filter_mc;
    localparam int W  = 9;
    localparam int CH = 2;
    localparam int SH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dc_filter_mc_if #(.WIDTH(W), .CHANNELS(CH)) if_s ();
    dc_filter_mc_if #(.WIDTH(W), .CHANNELS(CH)) if_w ();

    dc_filter_mc #(.WIDTH(W), .CHANNELS(CH), .SHIFT(SH), .SATURATE(1)) u_sat (
        .CLK_24M(clk), .reset(rst), .bus(if_s));
    dc_filter_mc #(.WIDTH(W), .CHANNELS(CH), .SHIFT(SH), .SATURATE(0)) u_wrap (
        .CLK_24M(clk), .reset(rst), .bus(if_w));

    int n_cmp  = 0;
    int n_fail = 0;
    int mx [2][CH];
    int my [2][CH];
    int ey [2][CH];
    int ec [2][CH];
    int exp_ov;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < CH; k++) begin
                mx[m][k] = 0; my[m][k] = 0;
            end
        exp_ov = 0;
    endtask

    // m=0 saturating, m=1 wrapping
    task automatic model_step(input int m, input int k, input int x, input bit byp);
        real ya;
        int d, y;
        if (byp) begin
            ey[m][k] = x; ec[m][k] = 0;
            mx[m][k] = x; my[m][k] = 0;
        end else begin
            ya = $floor(real'(my[m][k]) * 15.0 / 16.0 + 0.5);
            d  = x - mx[m][k] + int'(ya);
            ec[m][k] = (d > 255 || d < -256) ? 1 : 0;
            if (m == 0) y = (d > 255) ? 255 : ((d < -256) ? -256 : d);
            else        y = ((((d + 256) % 512) + 512) % 512) - 256;
            ey[m][k] = y;
            mx[m][k] = x; my[m][k] = y;
        end
    endtask

    task automatic set_bus(input logic en, input logic byp, input logic [CH*W-1:0] data);
        if_s.enable_3M = en; if_w.enable_3M = en;
        if_s.i_bypass  = byp; if_w.i_bypass = byp;
        if_s.c_data    = data; if_w.c_data  = data;
    endtask

    task automatic drive_strobe(input int x0, input int x1, input bit byp);
        logic [CH*W-1:0] data;
        data[0 +: W] = W'(x0);
        data[W +: W] = W'(x1);
        set_bus(1'b1, byp, data);
        @(posedge clk); #1;
        set_bus(1'b0, 1'($urandom), (CH*W)'($urandom));
        for (int m = 0; m < 2; m++) begin
            model_step(m, 0, x0, byp);
            model_step(m, 1, x1, byp);
        end
    endtask

    task automatic wait_check(input int elapsed, input string tag);
        int lat;
        lat = elapsed;
        while (if_s.o_valid !== 1'b1 && lat < 12) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, ".lat"}, lat, CH);
        chk({tag, ".vw"}, int'(if_w.o_valid), 1);
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("%s.ys%0d", tag, k), int'($signed(if_s.o_data[k*W +: W])), ey[0][k]);
            chk($sformatf("%s.yw%0d", tag, k), int'($signed(if_w.o_data[k*W +: W])), ey[1][k]);
            chk($sformatf("%s.cs%0d", tag, k), int'(if_s.o_clip[k]), ec[0][k]);
            chk($sformatf("%s.cw%0d", tag, k), int'(if_w.o_clip[k]), ec[1][k]);
        end
        chk({tag, ".ov"}, int'(if_s.o_overrun), exp_ov);
        @(posedge clk); #1;
        chk({tag, ".vlo"}, int'(if_s.o_valid), 0);
        chk({tag, ".blo"}, int'(if_s.o_busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".data"}, int'(if_s.o_data), 0);
        chk({tag, ".clip"}, int'(if_s.o_clip), 0);
        chk({tag, ".valid"}, int'(if_s.o_valid), 0);
        chk({tag, ".busy"}, int'(if_s.o_busy), 0);
        chk({tag, ".ov"}, int'(if_s.o_overrun), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1 [3];
        int v, a, prev_a;
        t1[0] = 100; t1[1] = 94; t1[2] = 88;
        set_bus(1'b0, 1'b0, '0);
        model_clear();

        // Reset state
        do_reset();
        chk_idle_zero("rst");

        // Step on ch0, silence on ch1
        for (int i = 0; i < 3; i++) begin
            drive_strobe(100, 0, 1'b0);
            chk("t1.busy", int'(if_s.o_busy), 1);
            wait_check(0, "t1");
            chk($sformatf("t1.step%0d", i), int'($signed(if_s.o_data[0 +: W])), t1[i]);
            chk("t1.ch1", int'($signed(if_s.o_data[W +: W])), 0);
        end

        // Large swing: filtered path, then from a bypass-cleaned state
        do_reset();
        drive_strobe(-200, 0, 1'b0); wait_check(0, "t2a");
        drive_strobe(200, 0, 1'b0);  wait_check(0, "t2b");
        drive_strobe(-200, 0, 1'b1); wait_check(0, "t2c");
        drive_strobe(200, 0, 1'b0);  wait_check(0, "t2d");
        chk("t2.sat", int'($signed(if_s.o_data[0 +: W])), 255);
        chk("t2.wrap", int'($signed(if_w.o_data[0 +: W])), -112);
        chk("t2.clips", int'(if_s.o_clip[0]), 1);
        chk("t2.clipw", int'(if_w.o_clip[0]), 1);

        // Constant offset on ch1 must settle without oscillation
        do_reset();
        prev_a = 1000;
        for (int i = 0; i < 200; i++) begin
            drive_strobe(0, -50, 1'b0);
            wait_check(0, "t3");
            v = int'($signed(if_s.o_data[W +: W]));
            if (i == 0) chk("t3.first", v, -50);
            a = (v < 0) ? -v : v;
            chk("t3.mono", int'(a <= prev_a), 1);
            prev_a = a;
        end

        // Strobe while busy: dropped, sticky overrun
        do_reset();
        drive_strobe(100, -30, 1'b0);
        @(posedge clk); #1;
        set_bus(1'b1, 1'b0, (CH*W)'($urandom));
        @(posedge clk); #1;
        set_bus(1'b0, 1'b0, '0);
        exp_ov = 1;
        wait_check(2, "t4a");
        drive_strobe(5, 5, 1'b0);
        wait_check(0, "t4b");

        // Bypass then filter with the same input
        do_reset();
        drive_strobe(37, 12, 1'b1); wait_check(0, "t5a");
        chk("t5.byp", int'($signed(if_s.o_data[0 +: W])), 37);
        drive_strobe(37, 12, 1'b0); wait_check(0, "t5b");
        chk("t5.flt", int'($signed(if_s.o_data[0 +: W])), 0);

        // Reset during RUN aborts the transaction
        do_reset();
        drive_strobe(50, 50, 1'b0); wait_check(0, "t6pre");
        drive_strobe(120, -7, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            chk("t6.novalid", int'(if_s.o_valid), 0);
            @(posedge clk); #1;
        end
        chk_idle_zero("t6");
        drive_strobe(100, 0, 1'b0); wait_check(0, "t6b");
        chk("t6.first", int'($signed(if_s.o_data[0 +: W])), 100);

        // Randomized traffic with occasional bypass
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive_strobe(int'($urandom_range(0, 511)) - 256,
                         int'($urandom_range(0, 511)) - 256,
                         ($urandom_range(0, 7) == 0));
            wait_check(0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
